// File: rtl/popcount_pipe_if.sv
// popcount_pipe_if: streaming handshake bundle for popcount_pipe.
//   Input side : in_valid/in_ready handshake, operand A, mode (0 = per-word,
//                1 = accumulate) and in_last (closes an accumulate packet).
//   Output side: out_valid/out_ready handshake, result Y and overflow flag ovf.
//   master modport: the producer/consumer environment around the block.
//   slave modport : the popcount block itself.
interface popcount_pipe_if #(
  parameter int WIDTH     = 32,
  parameter int ACC_WIDTH = 16
);
  logic                 in_valid;
  logic                 in_ready;
  logic [WIDTH-1:0]     A;
  logic                 mode;
  logic                 in_last;
  logic                 out_valid;
  logic                 out_ready;
  logic [ACC_WIDTH-1:0] Y;
  logic                 ovf;

  modport master (
    output in_valid, A, mode, in_last, out_ready,
    input  in_ready, out_valid, Y, ovf
  );

  modport slave (
    input  in_valid, A, mode, in_last, out_ready,
    output in_ready, out_valid, Y, ovf
  );
endinterface

// File: rtl/popcount_pipe.sv
// popcount_pipe: pipelined population count with valid/ready streaming.
//   clk, rst : rising-edge clock, asynchronous active-high reset.
//   io       : popcount_pipe_if.slave (in_valid/in_ready/A/mode/in_last in,
//              out_valid/out_ready/Y/ovf out).
// Structure: input capture register, L = log2(WIDTH) registered adder-tree
// levels, then a registered output stage that also owns the accumulator.
// A beat accepted at edge t is presented on Y after edge t+L+1.
// Accumulate beats touch the accumulator only when they reach the output
// stage, so stalls (which freeze the whole pipe) can never drop or repeat one.
module popcount_pipe #(
  parameter int WIDTH     = 32,
  parameter int ACC_WIDTH = 16
) (
  input logic            clk,
  input logic            rst,
  popcount_pipe_if.slave io
);
  localparam int L  = $clog2(WIDTH);
  localparam int CW = L + 1;

  // Single advance enable: the pipe moves only when the output register is
  // empty or being drained this cycle. No bubble collapse.
  logic en;
  assign en          = !io.out_valid || io.out_ready;
  assign io.in_ready = en;

  // Sideband shift registers; index s lines up with tree level s, index 0
  // with the input capture register.
  logic [L:0]       vld_pipe;
  logic [L:0]       mode_pipe;
  logic [L:0]       last_pipe;
  logic [WIDTH-1:0] a_q;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      vld_pipe  <= '0;
      mode_pipe <= '0;
      last_pipe <= '0;
      a_q       <= '0;
    end else if (en) begin
      vld_pipe  <= {vld_pipe[L-1:0],  io.in_valid};
      mode_pipe <= {mode_pipe[L-1:0], io.mode};
      // in_last is meaningless for per-word beats; mask it at the door.
      last_pipe <= {last_pipe[L-1:0], io.in_last & io.mode};
      a_q       <= io.A;
    end
  end

  // Adder tree: level s holds WIDTH>>s partial sums of s+1 bits each,
  // built from adjacent pairs of the previous level's s-bit partials.
  for (genvar s = 1; s <= L; s++) begin : g_lvl
    localparam int N = WIDTH >> s;
    logic [2*N-1:0][s-1:0] src;
    logic [N-1:0][s:0]     sum;
    logic [N-1:0][s:0]     part;

    if (s == 1) begin : g_src_in
      assign src = a_q;
    end else begin : g_src_lvl
      assign src = g_lvl[s-1].part;
    end

    for (genvar i = 0; i < N; i++) begin : g_pair
      assign sum[i] = {1'b0, src[2*i]} + {1'b0, src[2*i+1]};
    end

    always_ff @(posedge clk or posedge rst) begin
      if (rst)     part <= '0;
      else if (en) part <= sum;
    end
  end

  // Full count of the beat sitting in the last tree level.
  logic [CW-1:0] cnt;
  assign cnt = g_lvl[L].part;

  // Output stage and accumulator.
  logic [ACC_WIDTH-1:0] acc;
  logic                 sticky;
  logic [ACC_WIDTH-1:0] cnt_ext;
  logic [ACC_WIDTH:0]   acc_sum;
  logic                 carry;
  logic [ACC_WIDTH-1:0] sat_sum;
  logic                 out_valid_q;
  logic [ACC_WIDTH-1:0] y_q;
  logic                 ovf_q;

  assign cnt_ext = ACC_WIDTH'(cnt);
  assign acc_sum = {1'b0, acc} + {1'b0, cnt_ext};
  assign carry   = acc_sum[ACC_WIDTH];
  // Clamp at all-ones; a saturated accumulator keeps clamping to all-ones
  // for every further beat until the packet closes.
  assign sat_sum = carry ? {ACC_WIDTH{1'b1}} : acc_sum[ACC_WIDTH-1:0];

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      acc         <= '0;
      sticky      <= 1'b0;
      out_valid_q <= 1'b0;
      y_q         <= '0;
      ovf_q       <= 1'b0;
    end else if (en) begin
      // Either the register was empty or it is being drained this edge;
      // it only stays full if a completing result lands in it.
      out_valid_q <= 1'b0;
      if (vld_pipe[L]) begin
        if (!mode_pipe[L]) begin
          // Per-word result; an open packet's accumulator is left alone.
          out_valid_q <= 1'b1;
          y_q         <= cnt_ext;
          ovf_q       <= 1'b0;
        end else if (last_pipe[L]) begin
          // Packet close: emit and clear in the same edge so the next
          // packet's first beat can follow immediately.
          out_valid_q <= 1'b1;
          y_q         <= sat_sum;
          ovf_q       <= sticky | carry;
          acc         <= '0;
          sticky      <= 1'b0;
        end else begin
          acc    <= sat_sum;
          sticky <= sticky | carry;
        end
      end
    end
  end

  assign io.out_valid = out_valid_q;
  assign io.Y         = y_q;
  assign io.ovf       = ovf_q;
endmodule

// File: tb/tb_popcount_pipe.sv
// tb_popcount_pipe: directed self-checking bench for popcount_pipe.
// Three instances: 32/16 (latency, backpressure), 8/8 (accumulate,
// interleave, reset) and 8/4 (saturation). A vector table drives the
// single-cycle scenarios; hand-written sequences cover backpressure and
// mid-stream reset.
module tb_popcount_pipe;
  logic clk;
  logic rst;
  int   cyc;
  int   checks;
  int   errors;

  popcount_pipe_if #(.WIDTH(32), .ACC_WIDTH(16)) if32 ();
  popcount_pipe_if #(.WIDTH(8),  .ACC_WIDTH(8))  if8a ();
  popcount_pipe_if #(.WIDTH(8),  .ACC_WIDTH(4))  if8b ();

  popcount_pipe #(.WIDTH(32), .ACC_WIDTH(16)) u32  (.clk(clk), .rst(rst), .io(if32));
  popcount_pipe #(.WIDTH(8),  .ACC_WIDTH(8))  u8a  (.clk(clk), .rst(rst), .io(if8a));
  popcount_pipe #(.WIDTH(8),  .ACC_WIDTH(4))  u8b  (.clk(clk), .rst(rst), .io(if8b));

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial cyc = 0;
  always @(posedge clk) cyc = cyc + 1;

  // Output observation: a transfer happens on the edge following a negedge
  // where out_valid & out_ready; cyc is the edge that loaded the result.
  typedef struct {
    logic [15:0] y;
    logic        ovf;
    int          cyc;
  } obs_t;

  obs_t q32[$];
  obs_t q8a[$];
  obs_t q8b[$];

  always @(negedge clk) begin
    if (!rst) begin
      if (if32.out_valid && if32.out_ready) q32.push_back('{if32.Y, if32.ovf, cyc});
      if (if8a.out_valid && if8a.out_ready) q8a.push_back('{16'(if8a.Y), if8a.ovf, cyc});
      if (if8b.out_valid && if8b.out_ready) q8b.push_back('{16'(if8b.Y), if8b.ovf, cyc});
    end
  end

  typedef struct {
    int          d;    // 0: 32/16, 1: 8/8, 2: 8/4
    logic [31:0] a;
    logic        m;
    logic        l;
    logic        has;  // beat produces an output
    logic [15:0] ey;
    logic        eo;
  } vec_t;

  vec_t vt[$];

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
    end
  endtask

  task automatic drive(input int d, input logic v, input logic [31:0] a,
                       input logic m, input logic l);
    case (d)
      0: begin if32.in_valid = v; if32.A = a;      if32.mode = m; if32.in_last = l; end
      1: begin if8a.in_valid = v; if8a.A = a[7:0]; if8a.mode = m; if8a.in_last = l; end
      default: begin if8b.in_valid = v; if8b.A = a[7:0]; if8b.mode = m; if8b.in_last = l; end
    endcase
  endtask

  task automatic idle_all();
    drive(0, 1'b0, 32'h0, 1'b0, 1'b0);
    drive(1, 1'b0, 32'h0, 1'b0, 1'b0);
    drive(2, 1'b0, 32'h0, 1'b0, 1'b0);
  endtask

  function automatic logic rdy(input int d);
    case (d)
      0:       return if32.in_ready;
      1:       return if8a.in_ready;
      default: return if8b.in_ready;
    endcase
  endfunction

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1, "watchdog");
  end

  logic [31:0] bpw [10];
  int          t0;
  int          k;
  int          sz;
  int          idx;
  logic        pend;
  logic        pv;
  logic        po;
  logic [15:0] py;
  obs_t        o;

  initial begin
    checks = 0;
    errors = 0;

    // Vector table: {dut, A, mode, last, has_out, expected Y, expected ovf}
    vt.push_back('{0, 32'h00000000, 1'b0, 1'b0, 1'b1, 16'd0,  1'b0});
    vt.push_back('{0, 32'hFFFFFFFF, 1'b0, 1'b0, 1'b1, 16'd32, 1'b0});
    vt.push_back('{0, 32'h80000001, 1'b0, 1'b0, 1'b1, 16'd2,  1'b0});
    vt.push_back('{0, 32'h0000FFFF, 1'b0, 1'b1, 1'b1, 16'd16, 1'b0}); // last ignored
    vt.push_back('{1, 32'h000000FF, 1'b1, 1'b0, 1'b0, 16'd0,  1'b0});
    vt.push_back('{1, 32'h0000000F, 1'b1, 1'b0, 1'b0, 16'd0,  1'b0});
    vt.push_back('{1, 32'h00000001, 1'b1, 1'b1, 1'b1, 16'd13, 1'b0});
    vt.push_back('{2, 32'h000000FF, 1'b1, 1'b0, 1'b0, 16'd0,  1'b0});
    vt.push_back('{2, 32'h000000FF, 1'b1, 1'b1, 1'b1, 16'd15, 1'b1}); // saturates
    vt.push_back('{2, 32'h00000003, 1'b1, 1'b1, 1'b1, 16'd2,  1'b0}); // cleared acc
    vt.push_back('{1, 32'h0000000F, 1'b1, 1'b0, 1'b0, 16'd0,  1'b0});
    vt.push_back('{1, 32'h000000F0, 1'b0, 1'b0, 1'b1, 16'd4,  1'b0}); // interleaved word
    vt.push_back('{1, 32'h00000001, 1'b1, 1'b1, 1'b1, 16'd5,  1'b0});

    bpw = '{32'hDEADBEEF, 32'h00000001, 32'hFFFF0000, 32'h12345678, 32'h00000000,
            32'hFFFFFFFF, 32'hA5A5A5A5, 32'h80000000, 32'h7FFFFFFF, 32'h0F0F0F0F};

    // ---------------- reset ----------------
    rst = 1'b1;
    idle_all();
    if32.out_ready = 1'b1;
    if8a.out_ready = 1'b1;
    if8b.out_ready = 1'b1;
    repeat (3) step();
    chk("rst_out_valid32", if32.out_valid, 1'b0);
    chk("rst_y32",         if32.Y,         16'd0);
    chk("rst_ovf32",       if32.ovf,       1'b0);
    chk("rst_out_valid8",  if8a.out_valid, 1'b0);
    chk("rst_y8b",         if8b.Y,         4'd0);
    rst = 1'b0;
    step();
    chk("post_rst_in_ready32", if32.in_ready, 1'b1);
    chk("post_rst_in_ready8a", if8a.in_ready, 1'b1);
    chk("post_rst_in_ready8b", if8b.in_ready, 1'b1);

    // ---------------- table-driven vectors ----------------
    t0 = cyc + 1;
    for (int i = 0; i < vt.size(); i++) begin
      idle_all();
      drive(vt[i].d, 1'b1, vt[i].a, vt[i].m, vt[i].l);
      #1;
      chk("tbl_in_ready", rdy(vt[i].d), 1'b1);
      @(posedge clk);
      #1;
    end
    idle_all();
    for (int i = 0; i < 15; i++) begin
      chk("drain_in_ready32", if32.in_ready, 1'b1);
      step();
    end

    for (int d = 0; d < 3; d++) begin
      k  = 0;
      sz = (d == 0) ? q32.size() : (d == 1) ? q8a.size() : q8b.size();
      for (int i = 0; i < vt.size(); i++) begin
        if (vt[i].d == d && vt[i].has) begin
          if (k < sz) begin
            o = (d == 0) ? q32[k] : (d == 1) ? q8a[k] : q8b[k];
            chk($sformatf("tbl_y_d%0d_%0d", d, k),   o.y,   vt[i].ey);
            chk($sformatf("tbl_ovf_d%0d_%0d", d, k), o.ovf, vt[i].eo);
            // 32-bit instance beats were back-to-back: one result per cycle
            // starting L+1 = 6 edges after the first accept.
            if (d == 0) chk($sformatf("tbl_lat_%0d", k), o.cyc, t0 + 6 + k);
          end
          k++;
        end
      end
      chk($sformatf("tbl_out_count_d%0d", d), sz, k);
    end

    // ---------------- backpressure ----------------
    q32.delete();
    idx  = 0;
    pend = 1'b0;
    pv   = 1'b0;
    po   = 1'b1;
    py   = '0;
    for (int c = 0; c < 400 && !(idx == 10 && q32.size() == 10); c++) begin
      @(posedge clk);
      #1;
      if (pend) idx++;
      if (pv && !po) begin
        chk("bp_hold_valid", if32.out_valid, 1'b1);
        chk("bp_hold_y",     if32.Y,         py);
      end
      if32.out_ready = 1'($urandom_range(0, 1));
      if (idx < 10) drive(0, 1'b1, bpw[idx], 1'b0, 1'b0);
      else          drive(0, 1'b0, 32'h0, 1'b0, 1'b0);
      #1;
      chk("bp_in_ready", if32.in_ready, !(if32.out_valid && !if32.out_ready));
      pend = if32.in_valid && if32.in_ready;
      pv   = if32.out_valid;
      po   = if32.out_ready;
      py   = if32.Y;
    end
    if32.out_ready = 1'b1;
    idle_all();
    chk("bp_count", q32.size(), 10);
    for (int i = 0; i < 10; i++) begin
      if (i < q32.size()) begin
        chk($sformatf("bp_y_%0d", i), q32[i].y, 16'($countones(bpw[i])));
      end
    end

    // ---------------- reset mid-stream ----------------
    step();
    q8a.delete();
    drive(1, 1'b1, 32'hFF, 1'b1, 1'b0);  // opens a packet (acc -> 8)
    step();
    idle_all();
    repeat (5) step();
    drive(1, 1'b1, 32'h01, 1'b0, 1'b0);
    step();
    drive(1, 1'b1, 32'h03, 1'b0, 1'b0);
    step();
    drive(1, 1'b1, 32'h07, 1'b0, 1'b0);
    step();
    idle_all();
    rst = 1'b1;
    #1;
    chk("mid_rst_out_valid8", if8a.out_valid, 1'b0);
    chk("mid_rst_y8",         if8a.Y,         8'd0);
    chk("mid_rst_y32",        if32.Y,         16'd0);
    chk("mid_rst_no_out",     q8a.size(),     0);
    repeat (2) step();
    rst = 1'b0;
    repeat (10) step();
    chk("post_rst_silent", q8a.size(), 0);
    drive(1, 1'b1, 32'h01, 1'b1, 1'b1);
    step();
    idle_all();
    repeat (10) step();
    chk("post_rst_count", q8a.size(), 1);
    if (q8a.size() > 0) begin
      chk("post_rst_y",   q8a[0].y,   16'd1);
      chk("post_rst_ovf", q8a[0].ovf, 1'b0);
    end

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule

// File: doc/popcount_pipe.md
Name: popcount_pipe

Overview:
- Parametrised, pipelined population-count engine for WIDTH-bit operands. Built as a registered binary adder tree with one register per tree level.
- Valid/ready streaming on input and output, with backpressure.
- Two modes per beat:
  - per-word count;
  - multi-beat accumulate with saturation, for popcount over vectors longer than WIDTH.
- Drop-in sequential successor to the combinational int8 popcount in the benchmark set.

Parameters:
- WIDTH, 32, operand width; power of two, >= 2. L = log2(WIDTH) tree levels.
- ACC_WIDTH, 16, width of Y and of the accumulator; must be >= log2(WIDTH)+1.

Ports:
- clk  input  1  clock, rising edge.
- rst  input  1  asynchronous, active-high reset.
- in_valid  input  1  input beat valid.
- in_ready  output  1  block can accept a beat this cycle.
- A  input  WIDTH  operand bits to count.
- mode  input  1  0 = per-word count, 1 = accumulate.
- in_last  input  1  final beat of an accumulate packet; ignored when mode=0.
- out_valid  output  1  Y/ovf valid.
- out_ready  input  1  downstream accepts result.
- Y  output  ACC_WIDTH  count result, zero-extended.
- ovf  output  1  accumulate result saturated.

Behaviour:
- Reset (async assert, sync release):
  - all stage valid bits = 0;
  - accumulator = 0, sticky overflow = 0;
  - out_valid = 0, Y = 0, ovf = 0;
  - in_ready = 1 after reset release.
- Beat accepted when in_valid & in_ready.
- Global advance enable: en = !out_valid | out_ready. in_ready = en, combinational.
- When en = 0, every pipeline register holds (full stall, no bubble collapse).
- Pipeline:
  - Level 1 pairs input bits into 2-bit sums; level s sums adjacent (s)-bit partials into (s+1)-bit partials; level L holds the full count, log2(WIDTH)+1 bits.
  - Each level is registered. mode, in_last and a valid bit travel alongside as sideband.
  - Final output stage is registered.
- Latency: beat accepted at edge t produces its result at edge t+L+1, with no stalls. Example: WIDTH=32 gives 6 cycles. Throughput is 1 beat/cycle.
- mode=0 beat:
  - output stage loads Y = count zero-extended, ovf = 0, out_valid = 1;
  - accumulator and sticky overflow untouched, so a per-word beat may interleave inside an open accumulate packet.
- mode=1, in_last=0 beat:
  - acc <= sat(acc + count); sticky overflow |= carry-out;
  - no output produced.
- mode=1, in_last=1 beat:
  - Y = sat(acc + count), ovf = sticky | carry-out, out_valid = 1;
  - acc <= 0, sticky <= 0 in the same edge.
- sat(x) = min(x, 2^ACC_WIDTH - 1). Once the accumulator saturates it stays at max until the packet closes.
- Output handshake:
  - out_valid stays 1 with Y/ovf stable until out_valid & out_ready.
  - On that edge, the output stage either loads the next completing result or clears out_valid.
- Simultaneous: an output handshake and a new result arriving at the output stage on the same edge is a legal back-to-back transfer, with no dead cycle.
- Accumulate beats in flight are applied only when they reach the output stage. Stalls therefore never drop or double-count a beat.
- Reset mid-operation discards all in-flight beats and any open packet. Nothing is emitted after reset release.

Test Plan:
- WIDTH=32, mode=0, A=0x00000000, 0xFFFFFFFF, 0x80000001 on consecutive cycles, out_ready=1 -> Y=0, 32, 2 on cycles 6, 7, 8 after first accept; in_ready stays 1.
- WIDTH=8, ACC_WIDTH=8, mode=1, beats A=0xFF, 0x0F, 0x01(last) -> single out_valid with Y=13, ovf=0; no output for the first two beats.
- WIDTH=8, ACC_WIDTH=4, mode=1, beats 0xFF, 0xFF(last) -> Y=15 saturated, ovf=1. A following mode=1 packet 0x03(last) -> Y=2, ovf=0 (accumulator cleared).
- Backpressure: mode=0 stream of 10 random words, out_ready toggling 1/0 pseudo-randomly -> all 10 counts delivered in order, none lost or duplicated; Y stable while out_valid & !out_ready; in_ready low exactly when out_valid & !out_ready.
- Interleave: mode=1 0x0F, then mode=0 0xF0, then mode=1 0x01(last) -> outputs Y=4 (per-word) then Y=5 (packet).
- Assert rst mid-stream with 3 beats in flight and an open packet -> out_valid=0 and Y=0 immediately. Post-reset mode=1 0x01(last) -> Y=1.
